// File: rtl/sample_block_capture.sv
// Captures decimated samples from one selected channel of a packed multi-channel
// stream into a RAM-backed FIFO, single-shot or as a continuous ring.

module sample_block_capture_lane #(
    parameter int W_DIN  = 18,
    parameter int W_DOUT = 16
) (
    input  logic [W_DIN-1:0]  sample,
    output logic [W_DOUT-1:0] word
);
    // Low-order bits are dropped by design; fold them so lint sees them consumed.
    logic unused_lsbs;
    assign unused_lsbs = ^sample;
    assign word        = sample[W_DIN-1 -: W_DOUT];
endmodule

module sample_block_capture #(
    parameter  int N_CHAN = 8,
    parameter  int W_DIN  = 18,
    parameter  int W_DOUT = 16,
    parameter  int DEPTH  = 1024,
    localparam int W_ADDR = $clog2(DEPTH),
    localparam int W_SEL  = (N_CHAN > 1) ? $clog2(N_CHAN) : 1
) (
    input  logic                      clk_in,
    input  logic                      reset_in,
    input  logic [N_CHAN-1:0]         data_valid_in,
    input  logic [N_CHAN*W_DIN-1:0]   data_packed_in,
    input  logic [W_SEL-1:0]          chan_sel_in,
    input  logic [7:0]                decim_in,
    input  logic                      mode_in,
    input  logic                      start_in,
    input  logic                      stop_in,
    input  logic                      rd_en_in,
    output logic [W_DOUT-1:0]         data_out,
    output logic                      rd_valid_out,
    output logic [W_ADDR:0]           count_out,
    output logic                      busy_out,
    output logic                      done_out,
    output logic                      overrun_out,
    output logic                      err_out
);

    typedef enum logic [1:0] {IDLE, CAPTURE, DONE} state_t;

    localparam logic [W_SEL:0]    SEL_LIM  = (W_SEL+1)'(N_CHAN);
    localparam logic [W_ADDR:0]   FULL_CNT = (W_ADDR+1)'(DEPTH);
    localparam logic [W_ADDR:0]   LAST_CNT = (W_ADDR+1)'(DEPTH-1);
    localparam logic [W_ADDR:0]   ONE_C    = (W_ADDR+1)'(1);
    localparam logic [W_ADDR-1:0] ONE_A    = W_ADDR'(1);

    state_t state, state_nx;

    logic [W_SEL-1:0]  sel_q;
    logic [7:0]        decim_q;
    logic [7:0]        dec_cnt;
    logic              mode_q;
    logic [W_ADDR-1:0] wr_ptr, rd_ptr;
    logic [W_ADDR:0]   count, n_stored;
    logic [W_DOUT-1:0] rd_data;
    logic              rd_valid_q, overrun_q, err_q;

    logic [W_DOUT-1:0] mem [DEPTH];
    logic [N_CHAN-1:0][W_DOUT-1:0] lane_word;

    logic sel_ok, start_ok, hit, store, pop, full, overwrite;

    for (genvar k = 0; k < N_CHAN; k++) begin : g_lane
        sample_block_capture_lane #(.W_DIN(W_DIN), .W_DOUT(W_DOUT)) u_lane (
            .sample (data_packed_in[k*W_DIN +: W_DIN]),
            .word   (lane_word[k])
        );
    end

    // A valid start overrides every other activity in its cycle, including pops.
    assign sel_ok    = ({1'b0, chan_sel_in} < SEL_LIM);
    assign start_ok  = start_in & sel_ok;
    assign hit       = (state == CAPTURE) & data_valid_in[sel_q] & ~start_ok;
    assign store     = hit & (dec_cnt == 8'd0);
    assign pop       = rd_en_in & (count != '0) & ~start_ok;
    assign full      = (count == FULL_CNT);
    assign overwrite = store & ~pop & full & mode_q;

    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) state <= IDLE;
        else          state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        if (start_ok) begin
            state_nx = CAPTURE;
        end else begin
            case (state)
                CAPTURE: if (stop_in || (!mode_q && store && n_stored == LAST_CNT))
                             state_nx = DONE;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            sel_q      <= '0;
            decim_q    <= '0;
            mode_q     <= 1'b0;
            dec_cnt    <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            n_stored   <= '0;
            overrun_q  <= 1'b0;
            err_q      <= 1'b0;
            rd_valid_q <= 1'b0;
        end else begin
            err_q      <= start_in & ~sel_ok;
            rd_valid_q <= pop;
            if (start_ok) begin
                sel_q     <= chan_sel_in;
                decim_q   <= decim_in;
                mode_q    <= mode_in;
                dec_cnt   <= '0;
                wr_ptr    <= '0;
                rd_ptr    <= '0;
                count     <= '0;
                n_stored  <= '0;
                overrun_q <= 1'b0;
            end else begin
                if (hit)
                    dec_cnt <= (dec_cnt == decim_q) ? 8'd0 : dec_cnt + 8'd1;
                if (store) begin
                    wr_ptr   <= wr_ptr + ONE_A;
                    n_stored <= n_stored + ONE_C;
                end
                // When full, an unpopped store evicts the oldest word.
                if (pop || overwrite)
                    rd_ptr <= rd_ptr + ONE_A;
                if (overwrite)
                    overrun_q <= 1'b1;
                if (store && !pop && !full)
                    count <= count + ONE_C;
                else if (pop && !store)
                    count <= count - ONE_C;
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (store)
            mem[wr_ptr] <= lane_word[sel_q];
    end

    // Read-old-data on a same-address write keeps store+pop on a full ring correct.
    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in)  rd_data <= '0;
        else if (pop)  rd_data <= mem[rd_ptr];
    end

    assign data_out     = rd_data;
    assign rd_valid_out = rd_valid_q;
    assign count_out    = count;
    assign busy_out     = (state == CAPTURE);
    assign done_out     = (state == DONE);
    assign overrun_out  = overrun_q;
    assign err_out      = err_q;

endmodule

// File: tb/tb_sample_block_capture.sv
// Directed bench: two instances (DEPTH 1024 and DEPTH 4) share all inputs;
// each scenario checks the instance whose depth it targets.

module tb_sample_block_capture;
    localparam int NC = 6;
    localparam int WI = 18;
    localparam int WO = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic [NC-1:0]     dv;
    logic [NC*WI-1:0]  dp;
    logic [2:0]        sel;
    logic [7:0]        dec;
    logic              mode, start, stop, rd;

    logic [WO-1:0] dout_a, dout_b;
    logic          rdv_a, rdv_b;
    logic [10:0]   cnt_a;
    logic [2:0]    cnt_b;
    logic          busy_a, done_a, ovr_a, err_a;
    logic          busy_b, done_b, ovr_b, err_b;

    int errors = 0;
    int checks = 0;

    sample_block_capture #(.N_CHAN(NC), .W_DIN(WI), .W_DOUT(WO), .DEPTH(1024)) dut_a (
        .clk_in(clk), .reset_in(rst), .data_valid_in(dv), .data_packed_in(dp),
        .chan_sel_in(sel), .decim_in(dec), .mode_in(mode), .start_in(start),
        .stop_in(stop), .rd_en_in(rd), .data_out(dout_a), .rd_valid_out(rdv_a),
        .count_out(cnt_a), .busy_out(busy_a), .done_out(done_a),
        .overrun_out(ovr_a), .err_out(err_a));

    sample_block_capture #(.N_CHAN(NC), .W_DIN(WI), .W_DOUT(WO), .DEPTH(4)) dut_b (
        .clk_in(clk), .reset_in(rst), .data_valid_in(dv), .data_packed_in(dp),
        .chan_sel_in(sel), .decim_in(dec), .mode_in(mode), .start_in(start),
        .stop_in(stop), .rd_en_in(rd), .data_out(dout_b), .rd_valid_out(rdv_b),
        .count_out(cnt_b), .busy_out(busy_b), .done_out(done_b),
        .overrun_out(ovr_b), .err_out(err_b));

    always #5 clk = ~clk;

    typedef struct {
        logic [WI-1:0] sample;
        logic [WO-1:0] word;
    } vec_t;

    vec_t tv [8];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [2:0] s, input logic [7:0] d, input logic m);
        sel = s; dec = d; mode = m; start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic strobe(input int ch, input logic [WI-1:0] v);
        dv[ch] = 1'b1;
        dp[ch*WI +: WI] = v;
        tick();
        dv = '0;
    endtask

    task automatic pop();
        rd = 1'b1;
        tick();
        rd = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        tv[0] = '{18'h3FFFF, 16'hFFFF};
        tv[1] = '{18'h00003, 16'h0000};
        tv[2] = '{18'h00004, 16'h0001};
        tv[3] = '{18'h20000, 16'h8000};
        tv[4] = '{18'h1234C, 16'h48D3};
        tv[5] = '{18'h2AAAA, 16'hAAAA};
        tv[6] = '{18'h15555, 16'h5555};
        tv[7] = '{18'h00001, 16'h0000};

        rst = 1'b1; dv = '0; dp = '0; sel = '0; dec = '0;
        mode = 1'b0; start = 1'b0; stop = 1'b0; rd = 1'b0;
        repeat (3) tick();
        chk("rst busy", busy_a, 0);
        chk("rst done", done_a, 0);
        chk("rst count", cnt_a, 0);
        chk("rst rd_valid", rdv_a, 0);
        chk("rst overrun", ovr_a, 0);
        chk("rst err", err_a, 0);
        chk("rst data_out", dout_a, 0);
        chk("rst count_b", cnt_b, 0);
        rst = 1'b0;
        tick();
        pop();
        chk("empty pop after reset", rdv_a, 0);

        // MSB truncation table, four words per single-shot fill of the small buffer
        for (int b = 0; b < 2; b++) begin
            do_start(3'd2, 8'd0, 1'b0);
            for (int j = 0; j < 4; j++) strobe(2, tv[b*4+j].sample);
            chk("tbl done", done_b, 1);
            chk("tbl busy", busy_b, 0);
            chk("tbl count", cnt_b, 4);
            for (int j = 0; j < 4; j++) begin
                pop();
                chk("tbl rd_valid", rdv_b, 1);
                chk("tbl word", dout_b, tv[b*4+j].word);
            end
        end

        // Single-shot ramp filling 1024 words
        do_start(3'd3, 8'd0, 1'b0);
        for (int i = 0; i < 1024; i++) begin
            dv = 6'b001001;
            dp[3*WI +: WI] = WI'(i * 4);
            dp[0 +: WI]    = 18'h3_0000;
            tick();
            if (i == 1022) chk("ramp not done early", done_a, 0);
        end
        dv = '0;
        chk("ramp done", done_a, 1);
        chk("ramp count", cnt_a, 1024);
        strobe(3, 18'h3FFFC);
        chk("ramp no store in DONE", cnt_a, 1024);
        for (int i = 0; i < 1024; i++) begin
            pop();
            chk("ramp pop", dout_a, i);
        end
        chk("ramp drained", cnt_a, 0);

        // Decimation D=2 with neighbour channels strobing
        do_start(3'd1, 8'd2, 1'b0);
        for (int i = 0; i < 30; i++) begin
            dv = 6'b100011;
            dp[1*WI +: WI] = WI'((i + 100) * 4);
            tick();
            if (i % 4 == 3) begin
                dv = 6'b100001;
                tick();
            end
        end
        dv = '0;
        chk("decim count", cnt_a, 10);
        chk("decim busy", busy_a, 1);
        for (int k = 0; k < 10; k++) begin
            pop();
            chk("decim pop", dout_a, 3*k + 100);
        end

        // Continuous ring wrap on the 4-deep buffer
        do_start(3'd4, 8'd0, 1'b1);
        for (int v = 1; v <= 4; v++) strobe(4, WI'(v * 4));
        chk("wrap full count", cnt_b, 4);
        chk("wrap no overrun at full", ovr_b, 0);
        strobe(4, WI'(5 * 4));
        strobe(4, WI'(6 * 4));
        chk("wrap overrun", ovr_b, 1);
        chk("wrap count held", cnt_b, 4);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        chk("wrap done after stop", done_b, 1);
        for (int v = 3; v <= 6; v++) begin
            pop();
            chk("wrap pop", dout_b, v);
        end
        pop();
        chk("wrap empty pop valid", rdv_b, 0);
        chk("wrap data held", dout_b, 6);
        chk("wrap overrun sticky", ovr_b, 1);

        // Store and pop together on a full ring
        do_start(3'd4, 8'd0, 1'b1);
        for (int v = 10; v <= 13; v++) strobe(4, WI'(v * 4));
        chk("sim count", cnt_b, 4);
        dv[4] = 1'b1; dp[4*WI +: WI] = WI'(14 * 4); rd = 1'b1;
        tick();
        dv = '0; rd = 1'b0;
        chk("sim rd_valid", rdv_b, 1);
        chk("sim data", dout_b, 10);
        chk("sim count held", cnt_b, 4);
        chk("sim no overrun", ovr_b, 0);
        strobe(4, WI'(15 * 4));
        chk("sim overrun", ovr_b, 1);
        dv[4] = 1'b1; dp[4*WI +: WI] = WI'(16 * 4); rd = 1'b1;
        tick();
        dv = '0; rd = 1'b0;
        chk("sim2 data", dout_b, 12);
        chk("sim2 overrun kept", ovr_b, 1);
        chk("sim2 count", cnt_b, 4);
        sel = 3'd4; start = 1'b1; stop = 1'b1;
        tick();
        start = 1'b0; stop = 1'b0;
        chk("start+stop busy", busy_b, 1);
        chk("start+stop count", cnt_b, 0);
        chk("start+stop overrun", ovr_b, 0);

        // Invalid channel start leaves the capture untouched
        strobe(4, WI'(7 * 4));
        strobe(4, WI'(8 * 4));
        sel = 3'd6; start = 1'b1;
        tick();
        start = 1'b0;
        chk("err pulse", err_b, 1);
        chk("err busy kept", busy_b, 1);
        chk("err count kept", cnt_b, 2);
        tick();
        chk("err one cycle", err_b, 0);
        pop();
        chk("err buffer kept", dout_b, 7);
        strobe(4, WI'(9 * 4));
        chk("err channel kept", cnt_b, 2);

        // Asynchronous reset mid-capture
        do_start(3'd0, 8'd0, 1'b1);
        for (int i = 0; i < 500; i++) strobe(0, WI'(i * 4));
        chk("pre-reset count", cnt_a, 500);
        #2 rst = 1'b1;
        #1;
        chk("async rst busy", busy_a, 0);
        chk("async rst count", cnt_a, 0);
        chk("async rst done", done_a, 0);
        chk("async rst overrun", ovr_a, 0);
        chk("async rst err", err_a, 0);
        chk("async rst rd_valid", rdv_a, 0);
        chk("async rst data", dout_a, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        do_start(3'd4, 8'd0, 1'b0);
        chk("post-reset start", busy_a, 1);
        strobe(4, WI'(3 * 4));
        chk("post-reset store", cnt_a, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
